rv_one_to_two_demux: RTL and testbench

- Registered 1-to-N demultiplexer with valid/ready handshake; the inverse of the overlay's N-to-1 operand/result muxes.
- Steers one RV_BIT_NUM-wide word from a single producer (e.g. the ALU result) to one of OUT_NUM consumers (e.g. regfile writeback vs. store-data path).
- Each output has a one-entry register slice, so the producer sees backpressure only from the selected consumer.

---
 rtl/rv_demux_pkg.sv | 14 +
 rtl/rv_demux_slot.sv | 37 +++
 rtl/rv_one_to_two_demux.sv | 86 ++++++++
 tb/tb_rv_one_to_two_demux.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_demux_pkg.sv
// Shared defaults and slot state encoding for the registered 1-to-N valid/ready demux.
package rv_demux_pkg;

  localparam int unsigned DEF_RV_BIT_NUM = 32;
  localparam int unsigned DEF_OUT_NUM    = 2;
  localparam int unsigned DEF_SEL_WIDTH  = 1;
  localparam int unsigned DROP_CNT_WIDTH = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/rv_demux_slot.sv
// One-entry register slice with EMPTY/FULL state; one instance per demux output channel.
module rv_demux_slot
  import rv_demux_pkg::*;
#(
  parameter int unsigned RV_BIT_NUM = DEF_RV_BIT_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [RV_BIT_NUM-1:0] data_i,
  input  logic                  out_ready_i,
  output logic                  out_valid_o,
  output logic [RV_BIT_NUM-1:0] out_data_o,
  output logic                  slot_ready_o
);

  slot_state_e           state_q;
  logic [RV_BIT_NUM-1:0] data_q;

  // A load while FULL replaces the word being drained, giving one word per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else if (load_i) begin
      state_q <= SLOT_FULL;
      data_q  <= data_i;
    end else if ((state_q == SLOT_FULL) && out_ready_i) begin
      state_q <= SLOT_EMPTY;
    end
  end

  assign out_valid_o  = (state_q == SLOT_FULL);
  assign out_data_o   = data_q;
  assign slot_ready_o = (state_q == SLOT_EMPTY) || out_ready_i;

endmodule

// File: rtl/rv_one_to_two_demux.sv
// Registered 1-to-N demux: steers one producer word to a per-channel register slice.
// Optional saturating discard counter port drop_cnt when RV_DEMUX_DROP_CNT_EN is defined.
module rv_one_to_two_demux
  import rv_demux_pkg::*;
#(
  parameter int unsigned RV_BIT_NUM = DEF_RV_BIT_NUM,
  parameter int unsigned OUT_NUM    = DEF_OUT_NUM,
  parameter int unsigned SEL_WIDTH  = DEF_SEL_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SEL_WIDTH-1:0]          in_sel,
  input  logic [RV_BIT_NUM-1:0]         in_data,
  output logic [OUT_NUM-1:0]            out_valid,
  input  logic [OUT_NUM-1:0]            out_ready,
  output logic [RV_BIT_NUM*OUT_NUM-1:0] out_data,
  output logic                          drop_pulse
`ifdef RV_DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0]     drop_cnt
`endif
);

  logic [OUT_NUM-1:0] slot_ready;
  logic [OUT_NUM-1:0] load;
  logic               sel_hit;
  logic               drop_d;
  logic               drop_q;

  // Out-of-range selects are always accepted and discarded.
  always_comb begin
    in_ready = 1'b1;
    load     = '0;
    sel_hit  = 1'b0;
    for (int unsigned k = 0; k < OUT_NUM; k++) begin
      if (32'(in_sel) == k) begin
        sel_hit  = 1'b1;
        in_ready = slot_ready[k];
        load[k]  = in_valid && slot_ready[k];
      end
    end
    drop_d = in_valid && !sel_hit;
  end

  for (genvar k = 0; k < OUT_NUM; k++) begin : g_slot
    rv_demux_slot #(
      .RV_BIT_NUM(RV_BIT_NUM)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load[k]),
      .data_i      (in_data),
      .out_ready_i (out_ready[k]),
      .out_valid_o (out_valid[k]),
      .out_data_o  (out_data[k*RV_BIT_NUM +: RV_BIT_NUM]),
      .slot_ready_o(slot_ready[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= drop_d;
  end

  assign drop_pulse = drop_q;

`ifdef RV_DEMUX_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rv_one_to_two_demux.sv
// Bench for rv_one_to_two_demux (3 channels, 2-bit select) with a per-channel scoreboard.
module tb_rv_one_to_two_demux;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 3;
  localparam int unsigned SW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SW-1:0]    in_sel;
  logic [W-1:0]     in_data;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
  logic [W*N-1:0]   out_data;
  logic             drop_pulse;
`ifdef RV_DEMUX_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  rv_one_to_two_demux #(
    .RV_BIT_NUM(W),
    .OUT_NUM   (N),
    .SEL_WIDTH (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_pulse(drop_pulse)
`ifdef RV_DEMUX_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: words pushed on acceptance, popped when the channel handshakes.
  logic [W-1:0] sb_q [N][$];
  logic         drop_exp;
  int           cnt_exp;
  logic         mon_rdy;
  logic         mon_drop_now;
  logic [N-1:0] mon_v;
  logic [W-1:0] mon_slice;

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) sb_q[k].delete();
      drop_exp = 1'b0;
      cnt_exp  = 0;
    end else begin
      for (int k = 0; k < N; k++) mon_v[k] = (sb_q[k].size() != 0);
      if (32'(in_sel) < N) mon_rdy = !mon_v[in_sel] || out_ready[in_sel];
      else                 mon_rdy = 1'b1;
      total++;
      if (in_ready !== mon_rdy) begin
        bad++;
        $display("FAIL sb_in_ready t=%0t: got %b want %b", $time, in_ready, mon_rdy);
      end
      for (int k = 0; k < N; k++) begin
        total++;
        if (out_valid[k] !== mon_v[k]) begin
          bad++;
          $display("FAIL sb_valid ch%0d t=%0t: got %b want %b", k, $time, out_valid[k], mon_v[k]);
        end
        if (mon_v[k]) begin
          mon_slice = out_data[k*W +: W];
          total++;
          if (mon_slice !== sb_q[k][0]) begin
            bad++;
            $display("FAIL sb_data ch%0d t=%0t: got %h want %h", k, $time, mon_slice, sb_q[k][0]);
          end
        end
      end
      total++;
      if (drop_pulse !== drop_exp) begin
        bad++;
        $display("FAIL sb_drop_pulse t=%0t: got %b want %b", $time, drop_pulse, drop_exp);
      end
`ifdef RV_DEMUX_DROP_CNT_EN
      total++;
      if (drop_cnt !== 8'(cnt_exp)) begin
        bad++;
        $display("FAIL sb_drop_cnt t=%0t: got %0d want %0d", $time, drop_cnt, cnt_exp);
      end
`endif
      for (int k = 0; k < N; k++)
        if (mon_v[k] && out_ready[k]) void'(sb_q[k].pop_front());
      mon_drop_now = 1'b0;
      if (in_valid && mon_rdy) begin
        if (32'(in_sel) < N) sb_q[in_sel].push_back(in_data);
        else begin
          mon_drop_now = 1'b1;
          if (cnt_exp < 255) cnt_exp++;
        end
      end
      drop_exp = mon_drop_now;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    #2;
    total++;
    if (out_valid !== '0) begin bad++; $display("FAIL reset_valid: got %b want 000", out_valid); end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
    total++;
    if (drop_pulse !== 1'b0) begin bad++; $display("FAIL reset_drop: got %b want 0", drop_pulse); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_steer();
    out_ready = 3'b111;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 3'b001) begin bad++; $display("FAIL steer_valid: got %b want 001", out_valid); end
    total++;
    if (out_data[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL steer_data: got %h want deadbeef", out_data[31:0]); end
    tick();
    total++;
    if (out_valid !== 3'b000) begin bad++; $display("FAIL steer_empty: got %b want 000", out_valid); end
    total++;
    if (out_data[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL steer_hold: got %h want deadbeef", out_data[31:0]); end
  endtask

  task automatic test_backpressure();
    out_ready = 3'b010;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hAAAA_0001;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_a: got %b want 1", in_ready); end
    tick();
    in_sel = 2'd0; in_data = 32'hBBBB_0002;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_b: got %b want 0", in_ready); end
    tick();
    total++;
    if (out_data[31:0] !== 32'hAAAA_0001 || out_valid[0] !== 1'b1) begin
      bad++; $display("FAIL bp_hold_a: got v=%b d=%h want v=1 d=aaaa0001", out_valid[0], out_data[31:0]);
    end
    in_sel = 2'd1; in_data = 32'hCCCC_0003;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_c: got %b want 1", in_ready); end
    tick();
    total++;
    if (out_valid !== 3'b011 || out_data[63:32] !== 32'hCCCC_0003) begin
      bad++; $display("FAIL bp_deliver_c: got v=%b d=%h want v=011 d=cccc0003", out_valid, out_data[63:32]);
    end
    out_ready = 3'b011;
    in_sel = 2'd0; in_data = 32'hBBBB_0002;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_b2: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 3'b001 || out_data[31:0] !== 32'hBBBB_0002) begin
      bad++; $display("FAIL bp_deliver_b: got v=%b d=%h want v=001 d=bbbb0002", out_valid, out_data[31:0]);
    end
    tick();
  endtask

  task automatic test_full_throughput();
    logic [W-1:0] word;
    out_ready = 3'b001;
    in_sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      word = 32'h1000_0000 + 32'(i);
      in_valid = 1'b1; in_data = word;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL thr_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clk);
      #1;
      total++;
      if (out_valid[0] !== 1'b1 || out_data[31:0] !== word) begin
        bad++; $display("FAIL thr_out[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid[0], out_data[31:0], word);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL thr_end: got %b want 0", out_valid[0]); end
  endtask

  task automatic test_drain_load();
    out_ready = 3'b000;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h5555_AAAA;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid[1] !== 1'b1 || out_data[63:32] !== 32'h5555_AAAA) begin
      bad++; $display("FAIL dl_x: got v=%b d=%h want v=1 d=5555aaaa", out_valid[1], out_data[63:32]);
    end
    out_ready = 3'b010;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h0123_4567;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL dl_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid[1] !== 1'b1 || out_data[63:32] !== 32'h0123_4567) begin
      bad++; $display("FAIL dl_y: got v=%b d=%h want v=1 d=01234567", out_valid[1], out_data[63:32]);
    end
    tick();
    total++;
    if (out_valid[1] !== 1'b0) begin bad++; $display("FAIL dl_end: got %b want 0", out_valid[1]); end
  endtask

  task automatic test_out_of_range();
    out_ready = 3'b111;
    in_valid = 1'b1; in_sel = 2'd3; in_data = 32'hCAFE_F00D;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL oor_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 3'b000) begin bad++; $display("FAIL oor_valid: got %b want 000", out_valid); end
    total++;
    if (drop_pulse !== 1'b1) begin bad++; $display("FAIL oor_pulse: got %b want 1", drop_pulse); end
    tick();
    total++;
    if (drop_pulse !== 1'b0) begin bad++; $display("FAIL oor_pulse_end: got %b want 0", drop_pulse); end
`ifdef RV_DEMUX_DROP_CNT_EN
    in_valid = 1'b1; in_sel = 2'd3;
    repeat (300) tick();
    in_valid = 1'b0;
    tick();
    total++;
    if (drop_cnt !== 8'hFF) begin bad++; $display("FAIL oor_cnt_sat: got %h want ff", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 3'b000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h1111_1111;
    tick();
    in_sel = 2'd1; in_data = 32'h2222_2222;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 3'b000) begin bad++; $display("FAIL rmid_valid: got %b want 000", out_valid); end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL rmid_data: got %h want 0", out_data); end
    tick();
    rst = 1'b0;
    tick();
    out_ready = 3'b111;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h3333_3333;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 3'b100 || out_data[95:64] !== 32'h3333_3333) begin
      bad++; $display("FAIL rmid_after: got v=%b d=%h want v=100 d=33333333", out_valid, out_data[95:64]);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_steer();
    test_backpressure();
    test_full_throughput();
    test_drain_load();
    test_out_of_range();
    test_reset_mid();
    out_ready = 3'b111;
    repeat (3) tick();
    total++;
    if (out_valid !== 3'b000) begin bad++; $display("FAIL final_idle: got %b want 000", out_valid); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
